// File: rtl/keccak_pkg_mine.sv
// Shared types and constants for the keccak stream master.
// Header layout and mode encodings seen by the SHA3/SHAKE core.
package keccak_pkg_mine;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      MSG,
      DIG
   } stream_master_state_t;

   localparam int HDR_MODE_HI   = 63;
   localparam int HDR_INLEN_HI  = 61;
   localparam int HDR_OUTLEN_HI = 31;

   localparam logic [1:0] MODE_SHAKE128 = 2'b00;
   localparam logic [1:0] MODE_SHAKE256 = 2'b01;
   localparam logic [1:0] MODE_SHA3_256 = 2'b10;
   localparam logic [1:0] MODE_SHA3_512 = 2'b11;

endpackage

// File: rtl/keccak_stream_master_word_skid_reg.sv
// One-entry valid/ready register with registered data and valid.
// Accepts a new word whenever empty or being drained in the same cycle.
module word_skid_reg
   import keccak_pkg_mine::*;
#(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [W-1:0] up_data,
   output logic         dn_valid,
   input  logic         dn_ready,
   output logic [W-1:0] dn_data
);

   assign up_ready = !dn_valid || dn_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         dn_valid <= 1'b0;
         dn_data  <= '0;
      end else if (up_valid && up_ready) begin
         dn_valid <= 1'b1;
         dn_data  <= up_data;
      end else if (dn_ready) begin
         dn_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/keccak_stream_master.sv
// Host-side stream master for the SHA3/SHAKE core: sends header and
// message words to the core, returns the digest as a masked stream.
module keccak_stream_master
   import keccak_pkg_mine::*;
#(
   parameter int W     = 64,
   parameter int LEN_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic [LEN_W-1:0] cmd_in_len,
   input  logic [LEN_W-1:0] cmd_out_len,
   input  logic             msg_valid,
   output logic             msg_ready,
   input  logic [W-1:0]     msg_data,
   output logic [W-1:0]     core_data,
   output logic             core_valid_n,
   input  logic             core_ready,
   input  logic [W-1:0]     core_dout,
   input  logic             core_dvalid,
   output logic             core_ready_n,
   output logic             dig_valid,
   input  logic             dig_ready,
   output logic [W-1:0]     dig_data,
   output logic             dig_last,
   output logic             busy
);

   localparam int SH = $clog2(W);

   stream_master_state_t state;

   logic [LEN_W-1:0] n_msg, n_dig;
   logic [LEN_W-1:0] msg_cnt, core_cnt, dig_cnt;
   logic [SH-1:0]    rem;
   logic [LEN_W-1:0] in_len30;
   logic [W-1:0]     hdr_word, m_up_data, d_mask;
   logic             m_up_valid, m_up_ready, m_dn_valid;
   logic             cmd_fire, msg_fire, core_fire;
   logic             dig_load, dig_fire, d_up_ready, d_last_in;
   logic             msg_left, dig_left;
   logic [W:0]       d_dn;
   logic             unused_len_hi;

   function automatic logic [LEN_W-1:0] ceil_words(
      input logic [LEN_W-1:0] len
   );
      return (len >> SH) + LEN_W'(|len[SH-1:0]);
   endfunction

   assign unused_len_hi = ^cmd_in_len[LEN_W-1:LEN_W-2];
   assign in_len30 = {2'b00, cmd_in_len[LEN_W-3:0]};

   always_comb begin
      hdr_word = '0;
      hdr_word[HDR_MODE_HI -: 2]   = cmd_mode;
      hdr_word[HDR_INLEN_HI -: 30] = cmd_in_len[29:0];
      hdr_word[HDR_OUTLEN_HI:0]    = cmd_out_len;
   end

   // Header goes through the same register as the message words
   assign cmd_ready  = rst && !busy;
   assign cmd_fire   = cmd_valid && cmd_ready;
   assign msg_left   = msg_cnt < n_msg;
   assign msg_ready  = (state == MSG) && msg_left && m_up_ready;
   assign msg_fire   = msg_valid && msg_ready;
   assign m_up_valid = cmd_fire || msg_fire;
   assign m_up_data  = (state == IDLE) ? hdr_word : msg_data;

   word_skid_reg #(.W(W)) u_msg_reg (
      .clk      (clk),
      .rst      (rst),
      .up_valid (m_up_valid),
      .up_ready (m_up_ready),
      .up_data  (m_up_data),
      .dn_valid (m_dn_valid),
      .dn_ready (core_ready),
      .dn_data  (core_data)
   );

   assign core_valid_n = !m_dn_valid;
   assign core_fire    = m_dn_valid && core_ready;

   assign dig_left     = dig_cnt < n_dig;
   assign core_ready_n = !((state == DIG) && dig_left && d_up_ready);
   assign dig_load     = core_dvalid && !core_ready_n;
   assign d_last_in    = (dig_cnt + LEN_W'(1)) == n_dig;
   assign d_mask       = (d_last_in && rem != '0)
                       ? ~({W{1'b1}} << rem) : {W{1'b1}};

   word_skid_reg #(.W(W + 1)) u_dig_reg (
      .clk      (clk),
      .rst      (rst),
      .up_valid (dig_load),
      .up_ready (d_up_ready),
      .up_data  ({d_last_in, core_dout & d_mask}),
      .dn_valid (dig_valid),
      .dn_ready (dig_ready),
      .dn_data  (d_dn)
   );

   assign {dig_last, dig_data} = d_dn;
   assign dig_fire = dig_valid && dig_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         n_msg    <= '0;
         n_dig    <= '0;
         rem      <= '0;
         msg_cnt  <= '0;
         core_cnt <= '0;
         dig_cnt  <= '0;
      end else begin
         case (state)
            IDLE: if (cmd_fire) begin
               state    <= HDR;
               busy     <= 1'b1;
               n_msg    <= ceil_words(in_len30);
               n_dig    <= ceil_words(cmd_out_len);
               rem      <= cmd_out_len[SH-1:0];
               msg_cnt  <= '0;
               core_cnt <= '0;
               dig_cnt  <= '0;
            end
            HDR: if (core_fire) begin
               if (n_msg != '0) begin
                  state <= MSG;
               end else if (n_dig != '0) begin
                  state <= DIG;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            MSG: begin
               if (msg_fire) msg_cnt <= msg_cnt + LEN_W'(1);
               if (core_fire) begin
                  core_cnt <= core_cnt + LEN_W'(1);
                  if (core_cnt + LEN_W'(1) == n_msg) begin
                     if (n_dig != '0) begin
                        state <= DIG;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end
               end
            end
            DIG: begin
               if (dig_load) dig_cnt <= dig_cnt + LEN_W'(1);
               if (dig_fire && dig_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keccak_stream_master.sv
// Bench for keccak_stream_master: job table, random jobs and a
// queue-based model of the host, the core and the digest sink.
module tb_keccak_stream_master;
   import keccak_pkg_mine::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_mode;
   logic [31:0] cmd_in_len, cmd_out_len;
   logic        msg_valid, msg_ready;
   logic [63:0] msg_data, core_data, core_dout, dig_data;
   logic        core_valid_n, core_ready, core_dvalid, core_ready_n;
   logic        dig_valid, dig_ready, dig_last, busy;

   always #5 clk = ~clk;

   keccak_stream_master #(.W(64), .LEN_W(32)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_in_len(cmd_in_len),
      .cmd_out_len(cmd_out_len),
      .msg_valid(msg_valid), .msg_ready(msg_ready),
      .msg_data(msg_data),
      .core_data(core_data), .core_valid_n(core_valid_n),
      .core_ready(core_ready), .core_dout(core_dout),
      .core_dvalid(core_dvalid), .core_ready_n(core_ready_n),
      .dig_valid(dig_valid), .dig_ready(dig_ready),
      .dig_data(dig_data), .dig_last(dig_last), .busy(busy)
   );

   typedef struct {
      logic [1:0]  mode;
      int unsigned in_len;
      int unsigned out_len;
      int          cr;
      int          dr;
      logic [63:0] hdr;
   } job_t;

   typedef struct { int n_in; int n_dig; } cj_t;
   typedef struct { logic [63:0] data; logic last; } dw_t;

   job_t        jq[$];
   job_t        tbl[7];
   logic [63:0] exp_core[$], msg_pend[$], core_out[$];
   dw_t         exp_dig[$];
   cj_t         cjq[$];

   int tests = 0, fails = 0, cyc = 0;
   int cr_knob = 0, dr_knob = 0, stall = 0;
   int in_got = 0, out_sent = 0, core_in_beats = 0;
   int last_dig_cyc = -100, cmd_gap = 0;
   bit stall_done = 0, prev_hold = 0, prev_cmd = 0, core_ok = 0;
   logic [63:0] prev_data = '0;

   function automatic logic [63:0] hdr_model(
      logic [1:0] m, int unsigned il, int unsigned ol
   );
      return (64'(m) << 62) | (64'(il % 32'h4000_0000) << 32) | 64'(ol);
   endfunction

   task automatic chk(string name, logic [64:0] act, logic [64:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic start_job(job_t j);
      int nm, nd, rb;
      logic [63:0] w;
      dw_t d;
      nm = int'(((j.in_len % 32'h4000_0000) + 63) / 64);
      nd = int'((j.out_len + 63) / 64);
      rb = int'(j.out_len % 64);
      exp_core.push_back(j.hdr);
      for (int k = 0; k < nm; k++) begin
         w = {$urandom, $urandom};
         exp_core.push_back(w);
         msg_pend.push_back(w);
      end
      for (int k = 0; k < nd; k++) begin
         w = {$urandom, $urandom};
         core_out.push_back(w);
         d.last = (k == nd - 1);
         d.data = (d.last && rb != 0) ? (w & ((64'd1 << rb) - 64'd1)) : w;
         exp_dig.push_back(d);
      end
      cjq.push_back('{1 + nm, nd});
      cr_knob = j.cr;
      dr_knob = j.dr;
      stall_done = 0;
   endtask

   task automatic step();
      bit f_cmd, f_msg, f_cin, f_cout, f_dig;
      dw_t d;
      @(negedge clk);
      if (jq.size() > 0) begin
         cmd_valid   = 1'b1;
         cmd_mode    = jq[0].mode;
         cmd_in_len  = jq[0].in_len;
         cmd_out_len = jq[0].out_len;
      end else begin
         cmd_valid = 1'b0;
      end
      if (msg_pend.size() > 0) begin
         msg_valid = (cr_knob == 0) || ($urandom_range(0, 3) != 0);
         msg_data  = msg_pend[0];
      end else begin
         msg_valid = 1'b1;
         msg_data  = 64'hDEAD_BEEF_0BAD_F00D;
      end
      case (cr_knob)
         0: core_ready = 1'b1;
         1: core_ready = (cyc % 2) == 0;
         default: core_ready = 1'($urandom_range(0, 1));
      endcase
      core_ok = cjq.size() > 0 && in_got == cjq[0].n_in
                && out_sent < cjq[0].n_dig;
      if (core_ok) begin
         core_dvalid = (cr_knob != 2) || ($urandom_range(0, 1) == 1);
         core_dout   = core_out[0];
      end else begin
         core_dvalid = 1'b1;
         core_dout   = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      case (dr_knob)
         0: dig_ready = 1'b1;
         1: dig_ready = 1'($urandom_range(0, 1));
         default: dig_ready = (stall == 0);
      endcase
      #1;
      f_cmd  = cmd_valid && cmd_ready;
      f_msg  = msg_valid && msg_ready;
      f_cin  = !core_valid_n && core_ready;
      f_cout = core_dvalid && !core_ready_n;
      f_dig  = dig_valid && dig_ready;
      if (prev_cmd) chk("hdr_latency", 65'(core_valid_n), 65'(0));
      if (prev_hold)
         chk("core_hold", {core_valid_n, core_data}, {1'b0, prev_data});
      if (busy) chk("cmd_ready_busy", 65'(cmd_ready), 65'(0));
      if (dig_valid && !dig_ready)
         chk("core_ready_n_full", 65'(core_ready_n), 65'(1));
      if (f_cmd) begin
         cmd_gap = cyc - last_dig_cyc;
         start_job(jq.pop_front());
      end
      if (f_msg) begin
         if (msg_pend.size() == 0) chk("msg_extra", 65'(1), 65'(0));
         else void'(msg_pend.pop_front());
      end
      if (f_cin) begin
         core_in_beats++;
         if (exp_core.size() == 0) chk("core_extra", 65'(1), 65'(0));
         else chk("core_word", 65'(core_data), 65'(exp_core.pop_front()));
         in_got++;
      end
      if (f_cout) begin
         chk("core_out_legal", 65'(core_ok), 65'(1));
         if (core_ok) begin
            void'(core_out.pop_front());
            out_sent++;
         end
      end
      if (f_dig) begin
         if (exp_dig.size() == 0) chk("dig_extra", 65'(1), 65'(0));
         else begin
            d = exp_dig.pop_front();
            chk("dig_word", {dig_last, dig_data}, {d.last, d.data});
            if (d.last) last_dig_cyc = cyc;
         end
      end
      if (f_dig && dr_knob == 2 && !stall_done) begin
         stall = 10;
         stall_done = 1;
      end else if (stall > 0) begin
         stall--;
      end
      if (cjq.size() > 0 && in_got == cjq[0].n_in
          && out_sent == cjq[0].n_dig) begin
         void'(cjq.pop_front());
         in_got = 0;
         out_sent = 0;
      end
      prev_hold = !core_valid_n && !core_ready;
      prev_data = core_data;
      prev_cmd  = f_cmd;
      cyc++;
   endtask

   task automatic drain(int budget);
      int n;
      n = 0;
      while (!(jq.size() == 0 && exp_core.size() == 0 && exp_dig.size() == 0
               && cjq.size() == 0 && !busy) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) chk("drain_timeout", 65'(0), 65'(1));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      cmd_valid = 1'b0; msg_valid = 1'b0; core_dvalid = 1'b0;
      core_ready = 1'b0; dig_ready = 1'b0;
      @(negedge clk);
      chk("rst_core_valid_n", 65'(core_valid_n), 65'(1));
      chk("rst_core_ready_n", 65'(core_ready_n), 65'(1));
      chk("rst_cmd_ready", 65'(cmd_ready), 65'(0));
      chk("rst_msg_ready", 65'(msg_ready), 65'(0));
      chk("rst_dig", {dig_valid, dig_last}, 65'(0));
      chk("rst_busy", 65'(busy), 65'(0));
      chk("rst_core_data", 65'(core_data), 65'(0));
      chk("rst_dig_data", 65'(dig_data), 65'(0));
      rst = 1'b1;
      #1;
      chk("post_rst_cmd_ready", 65'(cmd_ready), 65'(1));
      chk("post_rst_idle", {busy, !core_valid_n}, 65'(0));
      jq.delete(); exp_core.delete(); msg_pend.delete();
      core_out.delete(); exp_dig.delete(); cjq.delete();
      in_got = 0; out_sent = 0; stall = 0;
      prev_hold = 0; prev_cmd = 0;
   endtask

   initial begin
      job_t j;
      int n;
      rst = 1'b0;
      cmd_valid = 1'b0; cmd_mode = '0; cmd_in_len = '0; cmd_out_len = '0;
      msg_valid = 1'b0; msg_data = '0; core_ready = 1'b0;
      core_dout = '0; core_dvalid = 1'b0; dig_ready = 1'b0;
      do_reset();

      tbl[0] = '{MODE_SHAKE128, 0, 256, 0, 0, 64'h0000_0000_0000_0100};
      tbl[1] = '{MODE_SHAKE256, 200, 100, 0, 1, 64'h4000_00C8_0000_0064};
      tbl[2] = '{MODE_SHA3_256, 320, 256, 1, 0, 64'h8000_0140_0000_0100};
      tbl[3] = '{MODE_SHA3_512, 64, 512, 0, 2, 64'hC000_0040_0000_0200};
      tbl[4] = '{MODE_SHAKE128, 1, 0, 2, 1, 64'h0000_0001_0000_0000};
      tbl[5] = '{MODE_SHAKE256, 129, 65, 2, 2, 64'h4000_0081_0000_0041};
      tbl[6] = '{MODE_SHA3_256, 32'hC000_0040, 64, 0, 0,
                 64'h8000_0040_0000_0040};
      for (int i = 0; i < 7; i++) begin
         jq.push_back(tbl[i]);
         drain(2000);
      end

      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < 3; k++) begin
            j.mode    = 2'($urandom_range(0, 3));
            j.in_len  = $urandom_range(0, 700);
            j.out_len = $urandom_range(0, 600);
            j.cr      = $urandom_range(0, 2);
            j.dr      = $urandom_range(0, 2);
            j.hdr     = hdr_model(j.mode, j.in_len, j.out_len);
            jq.push_back(j);
         end
         drain(6000);
      end

      jq.push_back('{MODE_SHAKE256, 128, 128, 0, 0,
                     hdr_model(MODE_SHAKE256, 128, 128)});
      jq.push_back('{MODE_SHA3_256, 64, 256, 0, 0,
                     hdr_model(MODE_SHA3_256, 64, 256)});
      drain(2000);
      chk("b2b_cmd_gap", 65'(cmd_gap), 65'(1));

      jq.push_back('{MODE_SHAKE128, 640, 128, 0, 0,
                     hdr_model(MODE_SHAKE128, 640, 128)});
      n = 0;
      while (core_in_beats < 4 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("mid_msg_timeout", 65'(0), 65'(1));
      core_in_beats = 0;
      do_reset();
      jq.push_back(tbl[1]);
      drain(2000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
